// File: rtl/user_bram_arbiter.sv
// user_bram_arbiter: round-robin sharing of the user BRAM between the WB slave path and the engine port
// BRAM_ARB_PERF_EN adds saturating grant/conflict counters; otherwise the perf_* ports read zero
module user_bram_arbiter #(
    parameter int unsigned DELAYS    = 10,
    parameter logic [31:0] ADDR_MASK = 32'h003FFFFF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        eng_req,
    input  logic        eng_we,
    input  logic [3:0]  eng_wstrb,
    input  logic [31:0] eng_adr,
    input  logic [31:0] eng_wdata,
    output logic        eng_done,
    output logic [31:0] eng_rdata,
    output logic        bram_en,
    output logic [3:0]  bram_we,
    output logic [31:0] bram_a0,
    output logic [31:0] bram_di,
    input  logic [31:0] bram_do,
    output logic [15:0] perf_wb_cnt,
    output logic [15:0] perf_eng_cnt,
    output logic [15:0] perf_conf_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
    localparam logic [7:0] L_LAST = DELAYS[7:0];
    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_last_eng;
    logic       r_sel_eng;
    logic       r_we;
    logic       w_wb_req;
    logic       w_any;
    logic       w_pick_eng;
    assign w_wb_req   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:23] == 9'h070);
    assign w_any      = w_wb_req | eng_req;
    // on a tie the engine wins only if WB was served last
    assign w_pick_eng = eng_req & (~w_wb_req | ~r_last_eng);
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_last_eng <= 1'b1;
            r_sel_eng  <= 1'b0;
            r_we       <= 1'b0;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            eng_done   <= 1'b0;
            eng_rdata  <= '0;
            bram_en    <= 1'b0;
            bram_we    <= '0;
            bram_a0    <= '0;
            bram_di    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_any) begin
                    r_state    <= S_ACCESS;
                    r_cnt      <= '0;
                    r_sel_eng  <= w_pick_eng;
                    r_last_eng <= w_pick_eng;
                    r_we       <= w_pick_eng ? eng_we : wbs_we_i;
                    bram_en    <= 1'b1;
                    bram_we    <= w_pick_eng ? eng_wstrb & {4{eng_we}} : wbs_sel_i & {4{wbs_we_i}};
                    bram_a0    <= (w_pick_eng ? eng_adr : wbs_adr_i) & ADDR_MASK;
                    bram_di    <= w_pick_eng ? eng_wdata : wbs_dat_i;
                end
                S_ACCESS: begin
                    bram_we <= '0;
                    r_cnt   <= r_cnt + 8'd1;
                    if (r_cnt == L_LAST) begin
                        r_state   <= S_RESP;
                        bram_en   <= 1'b0;
                        wbs_ack_o <= ~r_sel_eng;
                        eng_done  <= r_sel_eng;
                        if (!r_we && r_sel_eng) eng_rdata <= bram_do;
                        if (!r_we && !r_sel_eng) wbs_dat_o <= bram_do;
                    end
                end
                S_RESP: begin
                    r_state   <= S_IDLE;
                    wbs_ack_o <= 1'b0;
                    eng_done  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`ifdef BRAM_ARB_PERF_EN
    logic w_grant;
    logic w_both;
    assign w_grant = (r_state == S_IDLE) & w_any;
    assign w_both  = w_wb_req & eng_req;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            perf_wb_cnt   <= '0;
            perf_eng_cnt  <= '0;
            perf_conf_cnt <= '0;
        end else if (w_grant) begin
            if (!w_pick_eng && perf_wb_cnt != 16'hFFFF) perf_wb_cnt <= perf_wb_cnt + 16'd1;
            if (w_pick_eng && perf_eng_cnt != 16'hFFFF) perf_eng_cnt <= perf_eng_cnt + 16'd1;
            if (w_both && perf_conf_cnt != 16'hFFFF) perf_conf_cnt <= perf_conf_cnt + 16'd1;
        end
    end
`else
    assign perf_wb_cnt   = '0;
    assign perf_eng_cnt  = '0;
    assign perf_conf_cnt = '0;
`endif
endmodule

// File: tb/tb_user_bram_arbiter.sv
// tb_user_bram_arbiter: scoreboard bench for user_bram_arbiter with a word-level reference memory
module tb_user_bram_arbiter;
    localparam int DLY = 10;
    localparam logic [31:0] MASK = 32'h003FFFFF;
`ifdef BRAM_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = '0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        eng_req = 1'b0, eng_we = 1'b0;
    logic [3:0]  eng_wstrb = '0;
    logic [31:0] eng_adr = '0, eng_wdata = '0;
    logic        eng_done;
    logic [31:0] eng_rdata;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [31:0] bram_a0, bram_di;
    logic [31:0] bram_do = '0;
    logic [15:0] perf_wb_cnt, perf_eng_cnt, perf_conf_cnt;

    user_bram_arbiter #(.DELAYS(DLY), .ADDR_MASK(MASK)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .eng_req(eng_req), .eng_we(eng_we), .eng_wstrb(eng_wstrb), .eng_adr(eng_adr),
        .eng_wdata(eng_wdata), .eng_done(eng_done), .eng_rdata(eng_rdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_a0(bram_a0), .bram_di(bram_di), .bram_do(bram_do),
        .perf_wb_cnt(perf_wb_cnt), .perf_eng_cnt(perf_eng_cnt), .perf_conf_cnt(perf_conf_cnt)
    );

    always #5 clk = ~clk;

    // synchronous-read BRAM keyed by full word address, so unmasked bits show up as misses
    logic [31:0] mem [int];
    always @(posedge clk) begin : bram_model
        int k;
        logic [31:0] w;
        if (bram_en) begin
            k = int'(bram_a0 >> 2);
            w = mem.exists(k) ? mem[k] : 32'h0;
            bram_do <= w;
            for (int b = 0; b < 4; b++) if (bram_we[b]) w[8*b +: 8] = bram_di[8*b +: 8];
            mem[k] = w;
        end
    end

    int total = 0, bad = 0;
    logic [31:0] ref_mem [int];
    logic [31:0] wb_q[$], eng_q[$];
    logic [31:0] wb_last = '0, eng_last = '0;
    bit last_eng = 1'b1;
    int lw, le, wc1, wc2, rlw, rle, rwc1, rwc2;
    logic [31:0] a1, a2, d1, d2, ra1, ra2, rd1, rd2;
    bit hit;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // returns the value the port's read-data register must show after this access
    function automatic logic [31:0] ref_acc(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                            input logic [3:0] sel, input logic [31:0] last);
        int k;
        logic [31:0] w;
        k = int'((adr & MASK) >> 2);
        w = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
        if (!we) return w;
        for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = dat[8*b +: 8];
        ref_mem[k] = w;
        return last;
    endfunction

    function automatic logic [31:0] rnd_wb_adr();
        return 32'h38000000 | (32'($urandom_range(0, 1)) << 22) | (32'($urandom_range(0, 15)) << 2);
    endfunction

    function automatic logic [31:0] rnd_eng_adr();
        return ($urandom & 32'hFFC00000) | 32'h00200000 | (32'($urandom_range(0, 15)) << 2);
    endfunction

    task automatic wb_issue(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
        wb_last = ref_acc(we, adr, dat, sel, wb_last);
        wb_q.push_back(wb_last);
    endtask

    task automatic eng_issue(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        eng_req = 1'b1; eng_we = we; eng_adr = adr; eng_wdata = dat; eng_wstrb = sel;
        eng_last = ref_acc(we, adr, dat, sel, eng_last);
        eng_q.push_back(eng_last);
    endtask

    task automatic wb_rand();
        wb_issue(1'($urandom_range(0, 1)), rnd_wb_adr(), $urandom, 4'($urandom));
    endtask

    task automatic eng_rand();
        eng_issue(1'($urandom_range(0, 1)), rnd_eng_adr(), $urandom, 4'($urandom));
    endtask

    task automatic await(input bit eng, output int lat, output int wec, output logic [31:0] a0, output logic [31:0] di);
        bit seen, done;
        lat = 0; wec = 0; a0 = '0; di = '0; seen = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (bram_we != 4'h0) wec++;
            if (bram_en && !seen) begin seen = 1'b1; a0 = bram_a0; di = bram_di; end
            done = eng ? eng_done : wbs_ack_o;
        end while (!done && lat < 400);
        if (!done) begin
            total++; bad++;
            $display("FAIL %s_timeout: no completion within 400 cycles", eng ? "eng" : "wb");
        end
        if (eng) eng_req = 1'b0;
        else begin wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; end
    endtask

    task automatic tie_round();
        bit wb_first;
        wb_first = last_eng;
        @(negedge clk);
        wb_rand();
        eng_rand();
        fork
            await(1'b0, lw, wc1, a1, d1);
            await(1'b1, le, wc2, a2, d2);
        join
        chk("tie_wb_lat", 32'(lw), wb_first ? 32'(DLY + 2) : 32'(2 * DLY + 5));
        chk("tie_eng_lat", 32'(le), wb_first ? 32'(2 * DLY + 5) : 32'(DLY + 2));
        last_eng = wb_first;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wb_last = '0; eng_last = '0; last_eng = 1'b1;
    endtask

    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (wbs_ack_o) begin
                total++;
                if (wb_q.size() == 0) begin
                    bad++; $display("FAIL wb_ack_extra: got ack=1 want 0");
                end else begin
                    e = wb_q.pop_front();
                    if (wbs_dat_o !== e) begin bad++; $display("FAIL wb_rdata: got %h want %h", wbs_dat_o, e); end
                end
            end
            if (eng_done) begin
                total++;
                if (eng_q.size() == 0) begin
                    bad++; $display("FAIL eng_done_extra: got done=1 want 0");
                end else begin
                    e = eng_q.pop_front();
                    if (eng_rdata !== e) begin bad++; $display("FAIL eng_rdata: got %h want %h", eng_rdata, e); end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ctl", 32'({wbs_ack_o, eng_done, bram_en, bram_we}), 32'h0);
        chk("rst_a0", bram_a0, 32'h0);
        chk("rst_di", bram_di, 32'h0);
        chk("rst_rdata", wbs_dat_o | eng_rdata, 32'h0);
        chk("rst_perf", {perf_wb_cnt, perf_eng_cnt} | 32'(perf_conf_cnt), 32'h0);
        rst = 1'b0;
        // single WB write then read-back
        @(negedge clk);
        wb_issue(1'b1, 32'h38000010, 32'hDEADBEEF, 4'hF);
        await(1'b0, lw, wc1, a1, d1);
        chk("t1_lat", 32'(lw), 32'(DLY + 2));
        chk("t1_we_cycles", 32'(wc1), 32'd1);
        chk("t1_a0", a1, 32'h10);
        chk("t1_di", d1, 32'hDEADBEEF);
        @(negedge clk);
        wb_issue(1'b0, 32'h38000010, 32'h0, 4'hF);
        await(1'b0, lw, wc1, a1, d1);
        chk("t2_lat", 32'(lw), 32'(DLY + 2));
        chk("t2_we_cycles", 32'(wc1), 32'd0);
        chk("t2_rdata", wbs_dat_o, 32'hDEADBEEF);
        // unclaimed WB region
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_adr_i = 32'h30000000;
        wbs_sel_i = 4'hF; wbs_dat_i = 32'h12345678;
        hit = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (bram_en || wbs_ack_o) hit = 1'b1;
        end
        chk("t3_unclaimed_activity", 32'(hit), 32'h0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        // ties and round-robin fairness
        do_reset();
        tie_round();
        for (int r = 0; r < 10; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                hit = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (hit) eng_rand(); else wb_rand();
                await(hit, lw, wc1, a1, d1);
                last_eng = hit;
            end
            tie_round();
        end
        // reset in the fifth ACCESS cycle with the engine request held
        @(negedge clk);
        eng_issue(1'b0, rnd_eng_adr(), 32'h0, 4'h0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wb_last = '0; last_eng = 1'b1;
        chk("t5_ctl", 32'({wbs_ack_o, eng_done, bram_en, bram_we}), 32'h0);
        chk("t5_rdata", eng_rdata | wbs_dat_o, 32'h0);
        await(1'b1, le, wc2, a2, d2);
        chk("t5_lat", 32'(le), 32'(DLY + 2));
        // perf scenario: 1 engine (above), 1 tie, 2 WB singles
        tie_round();
        repeat (2) begin
            @(negedge clk);
            wb_rand();
            await(1'b0, lw, wc1, a1, d1);
            last_eng = 1'b0;
        end
        chk("perf_wb", 32'(perf_wb_cnt), PERF ? 32'd3 : 32'd0);
        chk("perf_eng", 32'(perf_eng_cnt), PERF ? 32'd2 : 32'd0);
        chk("perf_conf", 32'(perf_conf_cnt), PERF ? 32'd1 : 32'd0);
        // free-running random traffic on both ports
        fork
            for (int i = 0; i < 15; i++) begin
                repeat ($urandom_range(1, 6)) @(negedge clk);
                wb_rand();
                await(1'b0, rlw, rwc1, ra1, rd1);
                chk("rand_wb_lat_bound", 32'(rlw <= 2 * DLY + 5), 32'd1);
            end
            for (int j = 0; j < 15; j++) begin
                repeat ($urandom_range(1, 6)) @(negedge clk);
                eng_rand();
                await(1'b1, rle, rwc2, ra2, rd2);
                chk("rand_eng_lat_bound", 32'(rle <= 2 * DLY + 5), 32'd1);
            end
        join
        repeat (4) @(negedge clk);
        chk("wb_q_drained", 32'(wb_q.size()), 32'd0);
        chk("eng_q_drained", 32'(eng_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
